// File: rtl/seq_pkg.sv
// Shared definitions for the sequence step producer and the slice decoder:
// FSM state encoding, step word width and the bit layout of a step word.
package seq_pkg;

    localparam int SEQ_WORD_W       = 128;
    localparam int MIN_STEP_LEN_DEF = 4;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH0 = 3'd1,
        ST_WAIT0  = 3'd2,
        ST_RUN    = 3'd3,
        ST_DONE   = 3'd4
    } seq_state_e;

    // Step word field layout
    localparam int DAC0_LSB       = 0;
    localparam int DAC0_MSB       = 13;
    localparam int DAC1_LSB       = 16;
    localparam int DAC1_MSB       = 29;
    localparam int RESYNC_LSB     = 30;
    localparam int RESYNC_MSB     = 31;
    localparam int PDM_W          = 16;
    localparam int PDM0_LSB       = 32;
    localparam int PDM1_LSB       = 48;
    localparam int PDM2_LSB       = 64;
    localparam int PDM3_LSB       = 80;
    localparam int EN_DAC_LSB     = 96;
    localparam int EN_DAC_MSB     = 97;
    localparam int EN_PDM_LSB     = 98;
    localparam int EN_PDM_MSB     = 101;
    localparam int RAMP_DOWN_LSB  = 112;
    localparam int RAMP_DOWN_MSB  = 113;

    function automatic logic [31:0] clamp_step_len(input logic [31:0] len,
                                                   input logic [31:0] min_len);
        return (len < min_len) ? min_len : len;
    endfunction

endpackage

// File: rtl/seq_step_reader_if.sv
// Read port of the sequence BRAM as seen by the step reader.
interface seq_step_reader_if
    import seq_pkg::*;
#(
    parameter int ADDR_WIDTH = 11
);
    logic [ADDR_WIDTH-1:0] bram_addr;
    logic                  bram_en;
    logic [SEQ_WORD_W-1:0] bram_rdata;

    modport master (output bram_addr, output bram_en, input bram_rdata);
    modport slave  (input bram_addr, input bram_en, output bram_rdata);
endinterface

// File: rtl/seq_step_timer.sv
// Per-step cycle counter: latches the clamped step length at start and
// flags the first and last cycle of every step while running.
module seq_step_timer
    import seq_pkg::*;
#(
    parameter int MIN_LEN = MIN_STEP_LEN_DEF
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic        load,
    input  logic [31:0] step_len,
    input  logic        run,
    output logic        cnt_first,
    output logic        cnt_last
);
    logic [31:0] len_eff_reg;
    logic [31:0] cnt_reg;

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            len_eff_reg <= '0;
            cnt_reg     <= '0;
        end else begin
            if (load)
                len_eff_reg <= clamp_step_len(step_len, 32'(MIN_LEN));
            if (!run || cnt_last)
                cnt_reg <= '0;
            else
                cnt_reg <= cnt_reg + 32'd1;
        end
    end

    assign cnt_first = run && (cnt_reg == 32'd0);
    assign cnt_last  = run && (cnt_reg == len_eff_reg - 32'd1);

endmodule

// File: rtl/seq_step_reader.sv
// Walks the step table in sequence BRAM, holding each 128-bit step for
// len_eff cycles, looping num_repeats passes and then parking on zero.
module seq_step_reader
    import seq_pkg::*;
#(
    parameter int ADDR_WIDTH   = 11,
    parameter int MIN_STEP_LEN = MIN_STEP_LEN_DEF
) (
    input  logic                  clk,
    input  logic                  aresetn,
    input  logic                  enable,
    input  logic [31:0]           step_len,
    input  logic [ADDR_WIDTH:0]   num_steps,
    input  logic [15:0]           num_repeats,
    seq_step_reader_if.master     bram,
    output logic [SEQ_WORD_W-1:0] seq_data,
    output logic                  step_valid,
    output logic [ADDR_WIDTH-1:0] step_index,
    output logic [15:0]           repeat_index,
    output logic                  active,
    output logic                  done
);
    localparam logic [2:0] S_IDLE   = ST_IDLE;
    localparam logic [2:0] S_FETCH0 = ST_FETCH0;
    localparam logic [2:0] S_WAIT0  = ST_WAIT0;
    localparam logic [2:0] S_RUN    = ST_RUN;
    localparam logic [2:0] S_DONE   = ST_DONE;

    localparam logic [ADDR_WIDTH:0]   ONE_N   = 1;
    localparam logic [ADDR_WIDTH-1:0] ONE_IDX = 1;

    logic [2:0]            state_reg;
    logic [ADDR_WIDTH:0]   num_steps_reg;
    logic [15:0]           num_repeats_reg;
    logic [SEQ_WORD_W-1:0] pf_reg;
    logic [SEQ_WORD_W-1:0] seq_data_reg;
    logic                  rd_pending_reg;
    logic                  primed_reg;
    logic                  step_valid_reg;
    logic [ADDR_WIDTH-1:0] step_index_reg;
    logic [15:0]           repeat_index_reg;
    logic [ADDR_WIDTH-1:0] bram_addr_reg;
    logic                  bram_en_reg;

    logic                  running;
    logic                  abort;
    logic                  timer_run;
    logic                  timer_load;
    logic                  cnt_first;
    logic                  cnt_last;
    logic [ADDR_WIDTH:0]   last_idx;
    logic                  last_step;
    logic                  final_step;
    logic [ADDR_WIDTH-1:0] next_idx;

    assign running    = (state_reg == S_FETCH0) || (state_reg == S_WAIT0) || (state_reg == S_RUN);
    assign abort      = running && !enable;
    assign timer_run  = (state_reg == S_RUN) && enable;
    assign timer_load = (state_reg == S_IDLE) && enable;

    // Index arithmetic is done one bit wider so a full 2^ADDR_WIDTH table wraps cleanly.
    assign last_idx   = num_steps_reg - ONE_N;
    assign last_step  = ({1'b0, step_index_reg} == last_idx);
    assign final_step = last_step && (num_repeats_reg != 16'd0) &&
                        (repeat_index_reg == num_repeats_reg - 16'd1);
    assign next_idx   = last_step ? '0 : step_index_reg + ONE_IDX;

    seq_step_timer #(
        .MIN_LEN (MIN_STEP_LEN)
    ) u_timer (
        .clk       (clk),
        .aresetn   (aresetn),
        .load      (timer_load),
        .step_len  (step_len),
        .run       (timer_run),
        .cnt_first (cnt_first),
        .cnt_last  (cnt_last)
    );

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_reg        <= S_IDLE;
            num_steps_reg    <= '0;
            num_repeats_reg  <= '0;
            pf_reg           <= '0;
            seq_data_reg     <= '0;
            rd_pending_reg   <= 1'b0;
            primed_reg       <= 1'b0;
            step_valid_reg   <= 1'b0;
            step_index_reg   <= '0;
            repeat_index_reg <= '0;
            bram_addr_reg    <= '0;
            bram_en_reg      <= 1'b0;
        end else begin
            step_valid_reg <= 1'b0;
            bram_en_reg    <= 1'b0;
            rd_pending_reg <= bram_en_reg;
            if (rd_pending_reg)
                pf_reg <= bram.bram_rdata;

            if (abort) begin
                // Any read still in the BRAM pipeline is dropped.
                state_reg        <= S_IDLE;
                seq_data_reg     <= '0;
                rd_pending_reg   <= 1'b0;
                primed_reg       <= 1'b0;
                step_index_reg   <= '0;
                repeat_index_reg <= '0;
            end else begin
                unique case (state_reg)
                    S_IDLE: begin
                        seq_data_reg     <= '0;
                        step_index_reg   <= '0;
                        repeat_index_reg <= '0;
                        if (enable) begin
                            num_steps_reg   <= num_steps;
                            num_repeats_reg <= num_repeats;
                            if (num_steps == '0) begin
                                state_reg <= S_DONE;
                            end else begin
                                state_reg     <= S_FETCH0;
                                bram_addr_reg <= '0;
                                bram_en_reg   <= 1'b1;
                            end
                        end
                    end
                    S_FETCH0: begin
                        state_reg     <= S_WAIT0;
                        bram_addr_reg <= (num_steps_reg == ONE_N) ? '0 : ONE_IDX;
                        bram_en_reg   <= 1'b1;
                    end
                    S_WAIT0: begin
                        state_reg      <= S_RUN;
                        seq_data_reg   <= bram.bram_rdata;
                        step_valid_reg <= 1'b1;
                        primed_reg     <= 1'b1;
                    end
                    S_RUN: begin
                        // Step 1 was already fetched from WAIT0, so the first step skips its read.
                        if (cnt_first) begin
                            if (primed_reg) begin
                                primed_reg <= 1'b0;
                            end else if (!final_step) begin
                                bram_addr_reg <= next_idx;
                                bram_en_reg   <= 1'b1;
                            end
                        end
                        if (cnt_last) begin
                            if (final_step) begin
                                state_reg    <= S_DONE;
                                seq_data_reg <= '0;
                            end else begin
                                seq_data_reg   <= pf_reg;
                                step_valid_reg <= 1'b1;
                                step_index_reg <= next_idx;
                                if (last_step)
                                    repeat_index_reg <= repeat_index_reg + 16'd1;
                            end
                        end
                    end
                    S_DONE: begin
                        seq_data_reg <= '0;
                        if (!enable) begin
                            state_reg        <= S_IDLE;
                            step_index_reg   <= '0;
                            repeat_index_reg <= '0;
                        end
                    end
                    default: state_reg <= S_IDLE;
                endcase
            end
        end
    end

    assign bram.bram_addr = bram_addr_reg;
    assign bram.bram_en   = bram_en_reg;
    assign seq_data       = seq_data_reg;
    assign step_valid     = step_valid_reg;
    assign step_index     = step_index_reg;
    assign repeat_index   = repeat_index_reg;
    assign active         = running;
    assign done           = (state_reg == S_DONE);

endmodule

// File: tb/tb_seq_step_reader.sv
// Directed bench for seq_step_reader: a BRAM model feeds the DUT and a
// step-schedule model predicts every output on every cycle.
module tb_seq_step_reader;

    logic         clk;
    logic         aresetn;
    logic         enable;
    logic [31:0]  step_len;
    logic [11:0]  num_steps;
    logic [15:0]  num_repeats;
    logic [127:0] seq_data;
    logic         step_valid;
    logic [10:0]  step_index;
    logic [15:0]  repeat_index;
    logic         active;
    logic         done;

    seq_step_reader_if #(.ADDR_WIDTH(11)) bif ();

    seq_step_reader #(.ADDR_WIDTH(11), .MIN_STEP_LEN(4)) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .enable       (enable),
        .step_len     (step_len),
        .num_steps    (num_steps),
        .num_repeats  (num_repeats),
        .bram         (bif.master),
        .seq_data     (seq_data),
        .step_valid   (step_valid),
        .step_index   (step_index),
        .repeat_index (repeat_index),
        .active       (active),
        .done         (done)
    );

    logic [127:0] mem [0:2047];

    always @(posedge clk) begin
        if (bif.bram_en)
            bif.bram_rdata <= mem[bif.bram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     pulses   = 0;
    bit     m_on     = 1'b0;
    int     m_start  = 0;
    longint m_L      = 4;
    longint m_N      = 0;
    longint m_R      = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, act, exp);
    endtask

    // Expected outputs derived from the schedule: step s occupies cycles 2+s*L .. 1+(s+1)*L after the start edge.
    initial begin
        longint       k, s;
        logic [127:0] e_seq;
        logic         e_sv, e_act, e_done, quiet;
        logic [10:0]  e_si;
        logic [15:0]  e_ri;
        forever begin
            @(posedge clk);
            #2;
            cyc = cyc + 1;
            e_seq = '0; e_sv = 0; e_si = '0; e_ri = '0; e_act = 0; e_done = 0; quiet = 1;
            if (m_on && cyc >= m_start) begin
                k = longint'(cyc - m_start);
                if (m_N == 0) begin
                    e_done = 1;
                end else if (k < 2) begin
                    e_act = 1; quiet = 0;
                end else begin
                    s = (k - 2) / m_L;
                    if (m_R != 0 && s >= m_N * m_R) begin
                        e_done = 1;
                        e_si = 11'(m_N - 1);
                        e_ri = 16'(m_R - 1);
                    end else begin
                        e_act = 1; quiet = 0;
                        e_seq = mem[s % m_N];
                        e_sv  = ((k - 2) % m_L) == 0;
                        e_si  = 11'(s % m_N);
                        e_ri  = 16'((s / m_N) % 65536);
                    end
                end
            end
            chk("seq_data", seq_data, e_seq);
            chk("step_valid", 128'(step_valid), 128'(e_sv));
            chk("step_index", 128'(step_index), 128'(e_si));
            chk("repeat_index", 128'(repeat_index), 128'(e_ri));
            chk("active", 128'(active), 128'(e_act));
            chk("done", 128'(done), 128'(e_done));
            if (quiet)
                chk("bram_en_quiet", 128'(bif.bram_en), 128'(0));
            if (step_valid === 1'b1)
                pulses = pulses + 1;
        end
    end

    task automatic wait_neg(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_run(input logic [31:0] len, input logic [11:0] ns, input logic [15:0] nr);
        step_len    = len;
        num_steps   = ns;
        num_repeats = nr;
        enable      = 1'b1;
        m_L      = (len < 4) ? 4 : longint'(len);
        m_N      = longint'(ns);
        m_R      = longint'(nr);
        m_start  = cyc + 1;
        pulses   = 0;
        m_on     = 1'b1;
        $display("run start: step_len=%0d num_steps=%0d num_repeats=%0d", len, ns, nr);
    endtask

    task automatic stop_run();
        enable = 1'b0;
        m_on   = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++)
            mem[i] = {32'hA500_0000 | 32'(i), 32'(i * 7), 32'hC0DE_0000 + 32'(i), 32'(i + 1)};
        aresetn     = 1'b0;
        enable      = 1'b0;
        step_len    = 32'd10;
        num_steps   = 12'd4;
        num_repeats = 16'd1;

        wait_neg(3);
        chk("reset_zero", {seq_data, step_valid, active, done, bif.bram_en}, '0);
        aresetn = 1'b1;
        wait_neg(2);
        chk("idle_after_reset", 128'(active), 128'(0));

        // 4 steps x 10 cycles, single pass; config changes after start are ignored
        start_run(32'd10, 12'd4, 16'd1);
        wait_neg(1);
        chk("t1_k0_active", 128'(active), 128'(1));
        step_len = 32'd3; num_steps = 12'd1; num_repeats = 16'd0;
        wait_neg(2);
        chk("t1_step0_word", 128'(seq_data[31:0]), 128'(1));
        chk("t1_step0_valid", 128'(step_valid), 128'(1));
        wait_neg(10);
        chk("t1_step1_word", 128'(seq_data[31:0]), 128'(2));
        wait_neg(30);
        chk("t1_done", 128'(done), 128'(1));
        chk("t1_done_zero", seq_data, '0);
        chk("t1_pulses", 128'(pulses), 128'(4));
        stop_run();
        wait_neg(1);
        chk("t1_back_idle", 128'(done), 128'(0));
        wait_neg(1);

        // step_len clamped to 4, 3 steps x 2 passes
        start_run(32'd1, 12'd3, 16'd2);
        wait_neg(15);
        chk("t2_step3_index", 128'(step_index), 128'(0));
        chk("t2_step3_repeat", 128'(repeat_index), 128'(1));
        chk("t2_step3_valid", 128'(step_valid), 128'(1));
        wait_neg(12);
        chk("t2_done", 128'(done), 128'(1));
        chk("t2_pulses", 128'(pulses), 128'(6));
        stop_run();
        wait_neg(2);

        // empty table goes straight to DONE
        start_run(32'd10, 12'd0, 16'd1);
        wait_neg(1);
        chk("t3_done_now", 128'(done), 128'(1));
        chk("t3_not_active", 128'(active), 128'(0));
        wait_neg(5);
        stop_run();
        wait_neg(2);

        // endless loop over 2 steps
        start_run(32'd4, 12'd2, 16'd0);
        wait_neg(442);
        chk("t4_pulses_110", 128'(pulses), 128'(110));
        chk("t4_repeat_54", 128'(repeat_index), 128'(54));
        stop_run();
        wait_neg(2);
        start_run(32'd4, 12'd2, 16'd0);
        wait_neg(151);
        chk("t4_step37_valid", 128'(step_valid), 128'(1));
        chk("t4_step37_index", 128'(step_index), 128'(1));
        stop_run();
        wait_neg(1);
        chk("t4_abort_zero", {seq_data, active}, '0);
        start_run(32'd4, 12'd2, 16'd0);
        wait_neg(3);
        chk("t4_restart_index", 128'(step_index), 128'(0));
        chk("t4_restart_word", 128'(seq_data[31:0]), 128'(1));
        stop_run();
        wait_neg(2);

        // single step held for 3 passes
        start_run(32'd5, 12'd1, 16'd3);
        wait_neg(17);
        chk("t5_last_cycle_word", 128'(seq_data[31:0]), 128'(1));
        chk("t5_not_done_yet", 128'(done), 128'(0));
        wait_neg(1);
        chk("t5_done", 128'(done), 128'(1));
        chk("t5_pulses", 128'(pulses), 128'(3));
        stop_run();
        wait_neg(2);

        // asynchronous reset in the middle of RUN
        start_run(32'd10, 12'd4, 16'd0);
        wait_neg(20);
        chk("t6_running", 128'(active), 128'(1));
        #2;
        aresetn = 1'b0;
        enable  = 1'b0;
        m_on    = 1'b0;
        #1;
        chk("t6_async_clear", {seq_data, step_valid, active, done, bif.bram_en, step_index, repeat_index}, '0);
        wait_neg(3);
        aresetn = 1'b1;
        wait_neg(5);
        chk("t6_idle_after_release", 128'({active, done}), 128'(0));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
